// File: rtl/multi_gate_delay_gen.sv
// Multi-channel gate/delay generator. One external trigger fires N_CH channels.
// Each channel emits a delayed gate or a burst of gates with its own delay, width,
// period and count.
// Optional build macro: GDG_TRIG_STATS_EN adds trig_cnt/miss_cnt statistics ports.
module multi_gate_delay_gen #(
   parameter int unsigned N_CH  = 4,
   parameter int unsigned CNT_W = 32,
   parameter int unsigned NP_W  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_trigger,
   input  logic [N_CH-1:0]       ch_en,
   input  logic                  abort,
   input  logic [N_CH*CNT_W-1:0] delay,
   input  logic [N_CH*CNT_W-1:0] width,
   input  logic [N_CH*CNT_W-1:0] period,
   input  logic [N_CH*NP_W-1:0]  n_pulses,
   output logic [N_CH-1:0]       pulse,
   output logic [N_CH-1:0]       busy,
`ifdef GDG_TRIG_STATS_EN
   output logic [31:0]           trig_cnt,
   output logic [31:0]           miss_cnt,
`endif
   output logic                  any_busy
);

   localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [NP_W-1:0]  NpOne  = {{(NP_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {StIdle, StDelay, StHigh, StGap} state_e;

   logic r_sync1;
   logic r_sync2;
   logic r_sync3;
   logic r_trig_evt;

   // Two-FF synchroniser followed by a registered rising-edge detector
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1    <= 1'b0;
         r_sync2    <= 1'b0;
         r_sync3    <= 1'b0;
         r_trig_evt <= 1'b0;
      end else begin
         r_sync1    <= i_trigger;
         r_sync2    <= r_sync1;
         r_sync3    <= r_sync2;
         r_trig_evt <= r_sync2 & ~r_sync3;
      end
   end

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      logic [CNT_W-1:0] w_delay;
      logic [CNT_W-1:0] w_width;
      logic [CNT_W-1:0] w_period;
      logic [CNT_W-1:0] w_gap;
      logic [NP_W-1:0]  w_np;

      state_e           r_state;
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] r_delay;
      logic [CNT_W-1:0] r_width;
      logic [CNT_W-1:0] r_gap;
      logic [NP_W-1:0]  r_left;
      logic             r_pulse;

      assign w_delay  = delay[k*CNT_W +: CNT_W];
      assign w_width  = width[k*CNT_W +: CNT_W];
      assign w_period = period[k*CNT_W +: CNT_W];
      assign w_np     = n_pulses[k*NP_W +: NP_W];
      // Gap length is period_eff - width, never below one cycle; no width+1 overflow
      assign w_gap    = (w_period > w_width) ? (w_period - w_width) : CntOne;

      // Channel FSM: shadow-latch config on trigger, then DELAY -> HIGH (-> GAP -> HIGH)*
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_delay <= '0;
            r_width <= '0;
            r_gap   <= '0;
            r_left  <= '0;
            r_pulse <= 1'b0;
         end else if (abort) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
         end else begin
            unique case (r_state)
               StIdle: begin
                  if (r_trig_evt && ch_en[k]) begin
                     r_delay <= w_delay;
                     r_width <= w_width;
                     r_gap   <= w_gap;
                     r_left  <= (w_np == '0) ? '0 : (w_np - NpOne);
                     r_cnt   <= '0;
                     if (w_delay != '0) begin
                        r_state <= StDelay;
                     end else if (w_width != '0) begin
                        r_state <= StHigh;
                        r_pulse <= 1'b1;
                     end
                  end
               end
               StDelay: begin
                  if (r_cnt == r_delay - CntOne) begin
                     r_cnt <= '0;
                     if (r_width != '0) begin
                        r_state <= StHigh;
                        r_pulse <= 1'b1;
                     end else begin
                        r_state <= StIdle;
                     end
                  end else begin
                     r_cnt <= r_cnt + CntOne;
                  end
               end
               StHigh: begin
                  if (r_cnt == r_width - CntOne) begin
                     r_cnt   <= '0;
                     r_pulse <= 1'b0;
                     if (r_left != '0) begin
                        r_left  <= r_left - NpOne;
                        r_state <= StGap;
                     end else begin
                        r_state <= StIdle;
                     end
                  end else begin
                     r_cnt <= r_cnt + CntOne;
                  end
               end
               StGap: begin
                  if (r_cnt == r_gap - CntOne) begin
                     r_cnt   <= '0;
                     r_state <= StHigh;
                     r_pulse <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt + CntOne;
                  end
               end
               default: begin
                  r_state <= StIdle;
                  r_pulse <= 1'b0;
               end
            endcase
         end
      end

      assign pulse[k] = r_pulse;
      assign busy[k]  = (r_state != StIdle);
   end

   assign any_busy = |busy;

`ifdef GDG_TRIG_STATS_EN
   logic [31:0] r_trig_cnt;
   logic [31:0] r_miss_cnt;

   // Saturating trigger / missed-trigger statistics, cleared by abort
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_trig_cnt <= '0;
         r_miss_cnt <= '0;
      end else if (abort) begin
         r_trig_cnt <= '0;
         r_miss_cnt <= '0;
      end else if (r_trig_evt) begin
         if (r_trig_cnt != '1) r_trig_cnt <= r_trig_cnt + 32'd1;
         if ((|(ch_en & busy)) && (r_miss_cnt != '1)) r_miss_cnt <= r_miss_cnt + 32'd1;
      end
   end

   assign trig_cnt = r_trig_cnt;
   assign miss_cnt = r_miss_cnt;
`endif

endmodule
